// File: rtl/mpadder_modctrl_if.sv
// mpadder_modctrl_if
//   Bundle of the request/response signals of the modular add/sub sequencer
//   and of the operand/result path to the shared multi-precision adder.
//   slave  : the sequencer (mpadder_modctrl)
//   master : the requester plus the adder datapath it drives
//   Request  : start, subtract, in_a, in_b, in_m
//   Response : result, done, busy
//   Adder    : add_a, add_b, add_sub (to adder), add_result (from adder)
interface mpadder_modctrl_if #(
    parameter int WIDTH = 1027
);
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sub;
    logic [WIDTH:0]   add_result;

    modport slave (
        input  start, subtract, in_a, in_b, in_m, add_result,
        output result, done, busy, add_a, add_b, add_sub
    );

    modport master (
        output start, subtract, in_a, in_b, in_m, add_result,
        input  result, done, busy, add_a, add_b, add_sub
    );
endinterface

// File: rtl/mpadder_modctrl.sv
// mpadder_modctrl
//   Computes (a + b) mod M or (a - b) mod M by running a shared fixed-latency
//   multi-precision adder twice: pass 1 forms the raw sum/difference, pass 2
//   forms the modulus-corrected candidate, and the final result is picked from
//   the two by the carry/borrow bits. Both passes always run, so latency is a
//   constant 2*ADD_LAT cycles regardless of the data.
//   Ports:
//     clk    - rising-edge clock
//     resetn - asynchronous active-low reset
//     bus    - mpadder_modctrl_if.slave (request, response and adder path)
//   Parameters:
//     WIDTH   - operand/result width
//     ADD_LAT - adder latency in edges, 1..15
module mpadder_modctrl #(
    parameter int WIDTH   = 1027,
    parameter int ADD_LAT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    mpadder_modctrl_if.slave   bus
);

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r1;      // pass-1 result including carry/borrow bit
    logic [WIDTH-1:0] m_q;
    logic             sub_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            r1          <= '0;
            m_q         <= '0;
            sub_q       <= 1'b0;
            bus.result  <= '0;
            bus.done    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.add_a   <= '0;
            bus.add_b   <= '0;
            bus.add_sub <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // a and b live on in add_a/add_b; only M and the
                        // mode are needed again in pass 2.
                        m_q         <= bus.in_m;
                        sub_q       <= bus.subtract;
                        bus.add_a   <= bus.in_a;
                        bus.add_b   <= bus.in_b;
                        bus.add_sub <= bus.subtract;
                        cnt         <= CNT_LOAD;
                        bus.busy    <= 1'b1;
                        state       <= P1;
                    end
                end
                P1: begin
                    if (cnt == '0) begin
                        r1          <= bus.add_result;
                        // Pass 2 applies the opposite operation with M:
                        // add -> r1 - M, sub -> r1 + M.
                        bus.add_a   <= bus.add_result[WIDTH-1:0];
                        bus.add_b   <= m_q;
                        bus.add_sub <= ~sub_q;
                        cnt         <= CNT_LOAD;
                        state       <= P2;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                P2: begin
                    if (cnt == '0) begin
                        if (sub_q) begin
                            // a - b negative: take the +M corrected value.
                            bus.result <= r1[WIDTH] ? bus.add_result[WIDTH-1:0]
                                                    : r1[WIDTH-1:0];
                        end else begin
                            // r1 - M borrowed: r1 was already below M.
                            bus.result <= bus.add_result[WIDTH] ? r1[WIDTH-1:0]
                                                                : bus.add_result[WIDTH-1:0];
                        end
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpadder_modctrl.sv
// tb_mpadder_modctrl
//   Directed bench for mpadder_modctrl: one instance with ADD_LAT=1 and one
//   with ADD_LAT=3, each driving a bench adder model of matching true latency.
module tb_mpadder_modctrl;

    localparam int W = 1027;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mpadder_modctrl_if #(.WIDTH(W)) b1 ();
    mpadder_modctrl_if #(.WIDTH(W)) b3 ();

    mpadder_modctrl #(.WIDTH(W), .ADD_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1.slave)
    );
    mpadder_modctrl #(.WIDTH(W), .ADD_LAT(3)) dut3 (
        .clk(clk), .resetn(resetn), .bus(b3.slave)
    );

    function automatic logic [W:0] addf(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic s);
        return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    // Latency 1: combinational adder sampled at the next edge.
    assign b1.add_result = addf(b1.add_a, b1.add_b, b1.add_sub);

    // Latency 3: two register stages in front of the sampling edge.
    logic [W:0] s1, s2;
    always_ff @(posedge clk) begin
        s1 <= addf(b3.add_a, b3.add_b, b3.add_sub);
        s2 <= s1;
    end
    assign b3.add_result = s2;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (low 200 bits)", tag, obs[199:0], exp[199:0]);
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 0) ? b1.done : b3.done;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 0) ? b1.busy : b3.busy;
    endfunction
    function automatic logic [W-1:0] get_result(input int w);
        return (w == 0) ? b1.result : b3.result;
    endfunction

    task automatic drive(input int w, input logic st, input logic sub,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        if (w == 0) begin
            b1.start = st; b1.subtract = sub; b1.in_a = a; b1.in_b = b; b1.in_m = m;
        end else begin
            b3.start = st; b3.subtract = sub; b3.in_a = a; b3.in_b = b; b3.in_m = m;
        end
    endtask

    // One operation from a negedge: start sampled at edge T, then wait
    // (bounded) for done and check latency, result and busy/done shape.
    task automatic run_op(input int w, input string tag, input logic sub,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                          input logic [W-1:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        drive(w, 1'b1, sub, a, b, m);
        @(negedge clk);
        drive(w, 1'b0, 1'b0, '0, '0, '0);
        check({tag, " busy"}, W'(get_busy(w)), W'(1));
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (get_done(w)) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        check({tag, " result"}, {1'b0, get_result(w)}, {1'b0, exp});
        check({tag, " busy in done cycle"}, W'(get_busy(w)), W'(0));
        @(negedge clk);
        check({tag, " done single cycle"}, W'(get_done(w)), W'(0));
    endtask

    logic [W-1:0] mbig;
    int           ndone;
    logic [W-1:0] sa, sb, sexp;
    logic         ssub;

    initial begin
        mbig = (W'(1) << 1025) - W'(1);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);

        // Asynchronous reset before any clock edge.
        #2 resetn = 1'b0;
        #1;
        check("rst result", {1'b0, b1.result}, '0);
        check("rst done", W'(b1.done), W'(0));
        check("rst busy", W'(b1.busy), W'(0));
        check("rst add_a", {1'b0, b1.add_a}, '0);
        check("rst add_b", {1'b0, b1.add_b}, '0);
        check("rst add_sub", W'(b1.add_sub), W'(0));
        check("rst3 result", {1'b0, b3.result}, '0);
        @(negedge clk);
        resetn = 1'b1;

        // ADD_LAT = 1, M = 13
        run_op(0, "add 7+9",  1'b0, W'(7), W'(9), W'(13), W'(3), 2);
        run_op(0, "add 3+4",  1'b0, W'(3), W'(4), W'(13), W'(7), 2);
        run_op(0, "add 6+7",  1'b0, W'(6), W'(7), W'(13), W'(0), 2);
        run_op(0, "sub 4-9",  1'b1, W'(4), W'(9), W'(13), W'(8), 2);
        run_op(0, "sub 9-4",  1'b1, W'(9), W'(4), W'(13), W'(5), 2);
        run_op(0, "sub 5-5",  1'b1, W'(5), W'(5), W'(13), W'(0), 2);
        // Large modulus 2^1025-1
        run_op(0, "big add", 1'b0, mbig - W'(1), mbig - W'(1), mbig, mbig - W'(2), 2);
        run_op(0, "big sub", 1'b1, W'(0), mbig - W'(1), mbig, W'(1), 2);

        // ADD_LAT = 3
        run_op(1, "lat3 add 7+9", 1'b0, W'(7), W'(9), W'(13), W'(3), 6);

        // start held every cycle for 20 cycles, operands changing: only the
        // starts at edges 0,3,...,18 land in IDLE; done follows 2 edges later.
        ndone = 0;
        for (int c = 0; c < 26; c++) begin
            sa   = W'(c % 13);
            sb   = W'((5 * c + 3) % 13);
            ssub = c[0];
            drive(0, c < 20, ssub, sa, sb, W'(13));
            @(negedge clk);
            if (c >= 2 && (c - 2) % 3 == 0 && (c - 2) < 20) begin
                sa   = W'((c - 2) % 13);
                sb   = W'((5 * (c - 2) + 3) % 13);
                sexp = (c % 2 == 1) ? ((sa + W'(13) - sb) % W'(13)) : ((sa + sb) % W'(13));
                check($sformatf("spam done c=%0d", c), W'(b1.done), W'(1));
                check($sformatf("spam result c=%0d", c), {1'b0, b1.result}, {1'b0, sexp});
            end else begin
                check($sformatf("spam idle c=%0d", c), W'(b1.done), W'(0));
            end
            if (b1.done) ndone++;
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        check("spam done count", W'(ndone), W'(7));

        // Reset between the P1 and P2 edges.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, W'(7), W'(9), W'(13));
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst result", {1'b0, b1.result}, '0);
        check("midrst done", W'(b1.done), W'(0));
        check("midrst busy", W'(b1.busy), W'(0));
        check("midrst add_a", {1'b0, b1.add_a}, '0);
        check("midrst add_b", {1'b0, b1.add_b}, '0);
        check("midrst add_sub", W'(b1.add_sub), W'(0));
        @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b1.done) ndone++;
        end
        check("midrst no done", W'(ndone), W'(0));
        run_op(0, "post-rst add 7+9", 1'b0, W'(7), W'(9), W'(13), W'(3), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mpadder_modctrl.md
# mpadder_modctrl

Sequencer that computes a modular addition or subtraction, (a ± b) mod M, by driving one shared multi-precision adder/subtractor (the 1027-bit `mpadder` datapath) through two fixed-latency passes. Pass 1 produces the raw sum or difference. Pass 2 applies the modulus correction. The block sits between the exponentiation/Montgomery control and the adder, and owns the adder's operand inputs while busy.

## Interface
- `WIDTH`, 1027: operand and result width in bits.
- `ADD_LAT`, 1: adder latency in clock edges from operands valid to `add_result` valid; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `subtract` in 1: 0 = (a+b) mod M, 1 = (a−b) mod M; captured with `start`.
- `in_a` in WIDTH: operand a, captured with `start`.
- `in_b` in WIDTH: operand b, captured with `start`.
- `in_m` in WIDTH: modulus M, captured with `start`.
- `result` out WIDTH: modular result, registered; holds until the next completion.
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.
- `busy` out 1: high while an operation is in flight.
- `add_a` out WIDTH: adder operand A, registered.
- `add_b` out WIDTH: adder operand B, registered.
- `add_sub` out 1: adder mode, 1 = subtract, registered.
- `add_result` in WIDTH+1: adder output, equal to {0,A} ± {0,B} mod 2^(WIDTH+1). Bit WIDTH is the carry on add and the borrow (negative) on subtract.

## Operation
- Preconditions, checked by the bench and not by the RTL: in_a < M, in_b < M, 0 < M < 2^(WIDTH−1). Under these conditions the pass-1 sum fits in WIDTH bits.
- FSM states:
  - IDLE: wait for `start`.
  - P1: pass 1 in flight.
  - P2: pass 2 in flight.
- A `cnt` counter counts adder latency within P1 and P2.
- IDLE, `start`=1 at an edge:
  - capture a, b, M, subtract;
  - drive add_a=a, add_b=b, add_sub=subtract;
  - cnt=ADD_LAT−1; go to P1.
- P1: decrement cnt each edge. At the edge where cnt==0:
  - r1 = add_result.
  - Add: drive add_a=r1[WIDTH−1:0], add_b=M, add_sub=1.
  - Sub: drive add_a=r1[WIDTH−1:0], add_b=M, add_sub=0.
  - Reload cnt; go to P2.
- P2: at the edge where cnt==0, r2 = add_result, then:
  - Add: result = r2[WIDTH] ? r1[WIDTH−1:0] : r2[WIDTH−1:0] (keep r1 if r1 − M borrowed).
  - Sub: result = r1[WIDTH] ? r2[WIDTH−1:0] : r1[WIDTH−1:0] (add M back only if a − b was negative; r2 mod 2^WIDTH is exact).
  - Pulse `done`; go to IDLE.
- Pass 2 always executes, so latency does not depend on the data.
- `start` outside IDLE is ignored. Input changes after capture have no effect.
- add_a, add_b and add_sub hold their last values in IDLE.

## Timing
- Reset (asynchronous assert): state=IDLE, cnt=0, result=0, done=0, busy=0, add_a=0, add_b=0, add_sub=0, internal r1=0.
- A reset asserted mid-operation aborts the operation. No `done` is produced, and `result` reads 0.
- The first edge after `resetn` deasserts may sample `start`.
- With `start` sampled at edge T:
  - pass-1 operands are valid after T;
  - r1 is sampled at T+ADD_LAT;
  - r2 is sampled at T+2·ADD_LAT;
  - `result` and `done` are valid in the cycle following edge T+2·ADD_LAT. Latency = 2·ADD_LAT cycles.
- `busy` is high in the cycles after edges T … T+2·ADD_LAT−1. It is low in the `done` cycle.
- Back-to-back: `start` held high during the `done` cycle is accepted at the next edge. Throughput is one operation per 2·ADD_LAT+1 cycles.
- `done` is never high for two consecutive cycles.

## Test plan
- WIDTH=1027, ADD_LAT=1, M=13:
  - add 7+9: `done` at T+2, result=3.
  - add 3+4: result=7.
  - add 6+7: result=0.
- Sub, M=13:
  - 4−9: result=8.
  - 9−4: result=5.
  - 5−5: result=0.
- Large values, M=2^1025−1:
  - a=M−1, b=M−1, add: result=M−2.
  - a=0, b=M−1, sub: result=1.
- ADD_LAT=3, add 7+9 mod 13:
  - `add_result` is sampled only at T+3 and T+6;
  - `done` follows edge T+6; result=3;
  - a bench adder model with true latency 3 matches.
- `start` pulsed every cycle for 20 cycles with changing operands:
  - only operations captured in IDLE complete;
  - `done` is spaced 2·ADD_LAT+1 cycles apart;
  - each result matches the operands captured at its start.
- `resetn` pulsed low between the P1 and P2 edges:
  - all outputs are 0 immediately, without waiting for a clock edge;
  - no `done` pulse follows;
  - the next `start` (add 7+9 mod 13) returns 3.
